// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and a single-port RAM.
// The arbiter uses the slave modport; requesters and the RAM drive the master side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [15:0] ls_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single-port RAM, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is ls-over-if priority.
module mem_port_arbiter (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_t;

  state_t      state_q, state_d;
  logic        win_ls_q, win_ls_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] ls_rdata_q, ls_rdata_d;
  logic        pick_ls;

`ifdef MEM_ARB_RR_EN
  // last_ls_q = 1 means ls won the previous grant, so a tie goes to fetch
  logic last_ls_q, last_ls_d;
  assign pick_ls = bus.ls_req & (~bus.if_req | ~last_ls_q);
`else
  assign pick_ls = bus.ls_req;
`endif

  always_comb begin
    state_d     = state_q;
    win_ls_d    = win_ls_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_ls_d   = last_ls_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          state_d    = ACCESS;
          win_ls_d   = pick_ls;
          mem_addr_d = pick_ls ? bus.ls_addr : bus.if_addr;
          mem_we_d   = pick_ls & bus.ls_we;
          if (pick_ls) mem_wdata_d = bus.ls_wdata;
`ifdef MEM_ARB_RR_EN
          last_ls_d  = pick_ls;
`endif
        end
      end
      // mem_we_q marks a store; it needs no read phase
      ACCESS: state_d = mem_we_q ? IDLE : RDATA;
      RDATA: begin
        state_d = RESP;
        if (win_ls_q) ls_rdata_d = bus.mem_rdata;
        else          if_rdata_d = bus.mem_rdata;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_ls_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_ls_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      win_ls_q    <= win_ls_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_ls_q   <= last_ls_d;
`endif
    end
  end

  assign bus.if_gnt    = (state_q == ACCESS) & ~win_ls_q;
  assign bus.ls_gnt    = (state_q == ACCESS) &  win_ls_q;
  assign bus.if_rvalid = (state_q == RESP)   & ~win_ls_q;
  assign bus.ls_rvalid = (state_q == RESP)   &  win_ls_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a 256-word RAM model behind it.
// Read responses are queued at grant time and checked when rvalid appears.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {bit ls; logic [15:0] data; int cyc;} rsp_t;
  rsp_t sbq[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  bit ram_init = 1'b1;
  bit m_last_ls = 1'b0;
  logic [15:0] ram    [0:255];
  logic [15:0] shadow [0:255];

  function automatic logic [15:0] init_word(input int i);
    logic [15:0] w;
    w = 16'(i) * 16'h0101 ^ 16'h5a5a;
    if (i == 16'h0010) w = 16'hBEEF;
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, write on mem_we
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (bus.mem_we) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (!reset) begin
      if (bus.if_rvalid || bus.ls_rvalid) begin
        if (sbq.size() == 0) chk("spurious_rvalid", 32'(bus.if_rvalid | bus.ls_rvalid), 0);
        else begin
          e = sbq.pop_front();
          chk("rsp_port", 32'(bus.ls_rvalid), 32'(e.ls));
          chk("rsp_data", 32'(e.ls ? bus.ls_rdata : bus.if_rdata), 32'(e.data));
          chk("rsp_lat", cyc, e.cyc);
        end
      end
      if (bus.mem_we) chk("we_only_in_store_access", 32'(bus.ls_gnt), 1);
      if (bus.if_gnt && bus.ls_gnt) chk("dual_gnt", 32'(bus.if_gnt & bus.ls_gnt), 0);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  // called at the negedge on which a grant is observed
  task automatic grant_seen(input bit ls, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    chk("gnt_addr", 32'(bus.mem_addr), 32'(addr));
    chk("gnt_we", 32'(bus.mem_we), 32'(we));
    if (we) shadow[addr[7:0]] = wdata;
    else    sbq.push_back('{ls, shadow[addr[7:0]], cyc + 2});
    m_last_ls = ls;
  endtask

  task automatic xact(input bit ls, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    bit got = 1'b0;
    @(negedge clk);
    if (ls) begin
      bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_addr = addr; bus.ls_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int n = 1; n <= 10 && !got; n++) begin
      @(negedge clk);
      if (ls ? bus.ls_gnt : bus.if_gnt) begin
        got = 1'b1;
        chk("gnt_lat", n, 1);
        grant_seen(ls, we, addr, wdata);
        if (ls) bus.ls_req = 1'b0; else bus.if_req = 1'b0;
      end
    end
    if (!got) begin
      chk("gnt_timeout", 0, 1);
      bus.ls_req = 1'b0; bus.if_req = 1'b0;
    end
    wait_idle();
  endtask

  // both ports request together; persist re-raises ls after each of its grants
  task automatic contend(input bit persist, input logic [15:0] a_ls, input logic [15:0] a_if);
    int grants = 0;
    bit if_done = 1'b0, ls_done = 1'b0, exp_first_ls;
`ifdef MEM_ARB_RR_EN
    exp_first_ls = !m_last_ls;
`else
    exp_first_ls = 1'b1;
`endif
    @(negedge clk);
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = a_ls;
    bus.if_req = 1'b1; bus.if_addr = a_if;
    for (int n = 0; n < 80 && !(if_done && ls_done); n++) begin
      @(negedge clk);
      if (bus.ls_gnt || bus.if_gnt) begin
        grants++;
        if (grants == 1) chk("first_winner_ls", 32'(bus.ls_gnt), 32'(exp_first_ls));
      end
      if (bus.ls_gnt) begin
        grant_seen(1'b1, 1'b0, a_ls, 16'h0);
        bus.ls_req = 1'b0;
        if (!persist || if_done) ls_done = 1'b1;
      end else if (bus.if_gnt) begin
        chk("if_no_starve", 32'(grants <= 2), 1);
        grant_seen(1'b0, 1'b0, a_if, 16'h0);
        bus.if_req = 1'b0;
        if_done = 1'b1;
        if (!bus.ls_req) ls_done = 1'b1;
      end else if (persist && !if_done && !bus.ls_req) begin
        bus.ls_req = 1'b1;
      end
    end
    if (!(if_done && ls_done)) chk("contend_timeout", 0, 1);
    bus.ls_req = 1'b0; bus.if_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_gnt", 32'({bus.if_gnt, bus.ls_gnt}), 0);
    chk("rst_rvalid", 32'({bus.if_rvalid, bus.ls_rvalid}), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rdata", 32'({bus.if_rdata, bus.ls_rdata}), 0);
    ram_init = 1'b0;
    reset = 1'b0;

    xact(1'b1, 1'b0, 16'h0010, 16'h0);      // load BEEF
    xact(1'b1, 1'b1, 16'h0020, 16'h1234);   // store
    chk("idle_hold_addr", 32'(bus.mem_addr), 32'h0020);
    chk("idle_hold_wdata", 32'(bus.mem_wdata), 32'h1234);
    xact(1'b0, 1'b0, 16'h0020, 16'h0);      // fetch back 1234
    for (int k = 0; k < 4; k++) begin
      logic [15:0] a, d;
      a = 16'($urandom_range(32, 255));
      d = 16'($urandom);
      xact(1'b1, 1'b1, a, d);
      xact(k[0], 1'b0, a, 16'h0);
      xact(1'b0, 1'b0, 16'(k + 3), 16'h0);
    end

    for (int k = 0; k < 3; k++) contend(1'b0, 16'h0010, 16'h0020);
`ifdef MEM_ARB_RR_EN
    contend(1'b1, 16'h0030, 16'h0020);
`endif

    // reset during RDATA of a fetch aborts it
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 16'h0021;
    @(negedge clk);
    chk("abort_gnt", 32'(bus.if_gnt), 1);
    bus.if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_rvalid", 32'(bus.if_rvalid), 0);
    chk("abort_if_rdata", 32'(bus.if_rdata), 0);
    reset = 1'b0;
    m_last_ls = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_if_rdata_held", 32'(bus.if_rdata), 0);
    xact(1'b0, 1'b0, 16'h0020, 16'h0);
    contend(1'b0, 16'h0010, 16'h0021);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on posedge clk.
REQ-002 clk  in  1  system clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 if_req  in  1  instruction-fetch read request, held until if_gnt.
REQ-005 if_addr  in  16  fetch address.
REQ-006 if_gnt  out  1  one-cycle grant pulse to fetch.
REQ-007 if_rvalid  out  1  one-cycle fetch read-data-valid pulse.
REQ-008 if_rdata  out  16  fetch read data, held until next fetch response.
REQ-009 ls_req  in  1  load/store request, held until ls_gnt.
REQ-010 ls_we  in  1  1 = store, 0 = load.
REQ-011 ls_addr  in  16  load/store address.
REQ-012 ls_wdata  in  16  store data.
REQ-013 ls_gnt  out  1  one-cycle grant pulse to load/store.
REQ-014 ls_rvalid  out  1  one-cycle load-data-valid pulse.
REQ-015 ls_rdata  out  16  load data, held until next load response.
REQ-016 mem_addr  out  16  single-port RAM address, registered.
REQ-017 mem_we  out  1  RAM write enable, registered.
REQ-018 mem_wdata  out  16  RAM write data, registered.
REQ-019 mem_rdata  in  16  RAM read data, valid one cycle after address.
REQ-020 busy  out  1  high whenever state is not IDLE.

Function
REQ-021 States SHALL be IDLE, ACCESS, RDATA, RESP; one transaction in flight at a time.
REQ-022 In IDLE with any request, the winner's addr/we/wdata SHALL be registered onto mem_* and state SHALL go to ACCESS; with no request, stay in IDLE.
REQ-023 In ACCESS, the winner's gnt SHALL be 1 for exactly that cycle; mem_we SHALL be 1 only for a store and only in ACCESS.
REQ-024 ACCESS SHALL go to IDLE for a store, and to RDATA for a read (fetch or load).
REQ-025 In RDATA, mem_rdata SHALL be captured into the winner's rdata register; next state SHALL be RESP.
REQ-026 In RESP, the winner's rvalid SHALL be 1 for one cycle; next state SHALL be IDLE.
REQ-027 Latency from request sampled in IDLE (cycle N): store gnt at N+1; read gnt at N+1, rvalid at N+3.
REQ-028 A requester SHALL drop req on the cycle after it sees gnt; the arbiter SHALL NOT sample requests outside IDLE.
REQ-029 if_we is implicitly 0; a fetch SHALL never assert mem_we.
REQ-030 In fixed-priority mode, when both requests are present in IDLE, ls SHALL win.
REQ-031 The non-winning request SHALL remain pending and SHALL be served in the next IDLE cycle if still asserted.
REQ-032 if_rdata/ls_rdata SHALL change only in RDATA of their own port's read.
REQ-033 mem_addr/mem_wdata SHALL hold their last value in IDLE; mem_we SHALL be 0 outside ACCESS.

Reset
REQ-034 On reset: state = IDLE; all gnt, rvalid, mem_we and busy SHALL be 0; mem_addr, mem_wdata, if_rdata and ls_rdata SHALL be 0x0000; round-robin pointer SHALL select ls first.
REQ-035 Reset asserted in any state SHALL abort the transaction: no further gnt, rvalid or mem_we for it.

Configuration
REQ-036 Macro MEM_ARB_RR_EN: when defined, a one-bit last-grant pointer SHALL make a simultaneous request go to the port not granted last; the pointer SHALL update on every grant.
REQ-037 Without MEM_ARB_RR_EN, arbitration SHALL be fixed priority with ls over if, and no pointer SHALL exist.

Verification
REQ-038 Load at 0x0010 with RAM[0x0010]=0xBEEF -> ls_gnt at N+1, ls_rvalid at N+3, ls_rdata=0xBEEF, mem_we=0 throughout.
REQ-039 Store 0x1234 to 0x0020 -> mem_we=1 only at N+1 with mem_addr=0x0020; a later fetch from 0x0020 returns if_rdata=0x1234.
REQ-040 if_req and ls_req together, both held, fixed mode -> ls served first, then if; with MEM_ARB_RR_EN, a third simultaneous pair goes to the port not granted last.
REQ-041 Reset pulsed in RDATA of a fetch -> no if_rvalid; if_rdata=0x0000; busy=0 on the next cycle.
REQ-042 Continuous ls_req with MEM_ARB_RR_EN and if_req held -> if granted within two transactions, so no starvation.
